// File: rtl/instruction_fetch_if.sv
// Fetch-unit signal bundle: instruction-memory read port, execute redirect and decoder handoff.
// master = fetch unit, slave = memory/execute/decoder environment.
interface instruction_fetch_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        dec_ready;

   modport master (
      output mem_req, mem_addr, instr, instr_pc, instr_valid,
      input  mem_ack, mem_rdata, br_taken, br_target, dec_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr, instr_pc, instr_valid,
      output mem_ack, mem_rdata, br_taken, br_target, dec_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory read at a time, feeding a 2-entry {instr, pc} buffer.
// A branch redirect flushes the buffer and turns any in-flight read into one whose data is dropped.
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic            clk,
   input logic            rst_n,
   instruction_fetch_if.master bus
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] fetch_pc;
   logic [15:0] mem_addr_q;
   logic [15:0] fifo_instr [2];
   logic [15:0] fifo_pc    [2];
   logic [1:0]  count;
   logic        issue;
   logic        push;
   logic        pop;

   always_comb begin
      issue = (state == IDLE) && !bus.br_taken && (count < 2'd2);
      push  = (state == WAIT) && bus.mem_ack && !bus.br_taken;
      pop   = bus.dec_ready && (count != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = WAIT;
         WAIT: begin
            if (bus.mem_ack)       state_nxt = IDLE;
            else if (bus.br_taken) state_nxt = DROP;
         end
         DROP:    if (bus.mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req     = (state != IDLE);
      bus.mem_addr    = mem_addr_q;
      bus.instr_valid = (count != 2'd0);
      bus.instr       = (count != 2'd0) ? fifo_instr[0] : '0;
      bus.instr_pc    = (count != 2'd0) ? fifo_pc[0]    : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         mem_addr_q <= '0;
      end else begin
         if (bus.br_taken) fetch_pc <= bus.br_target;
         else if (issue)   fetch_pc <= fetch_pc + 16'd1;
         if (issue) mem_addr_q <= fetch_pc;
      end
   end

   // Entry 0 is always the head; a pop shifts entry 1 down, a push fills slot count[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (bus.br_taken) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               fifo_instr[count[0]] <= bus.mem_rdata;
               fifo_pc[count[0]]    <= mem_addr_q;
               count                <= count + 2'd1;
            end
            2'b01: begin
               fifo_instr[0] <= fifo_instr[1];
               fifo_pc[0]    <= fifo_pc[1];
               count         <= count - 2'd1;
            end
            2'b11: begin
               fifo_instr[0] <= bus.mem_rdata;
               fifo_pc[0]    <= mem_addr_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level model (request slot + instruction queue).
module tb_instruction_fetch;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   instruction_fetch_if b0 ();
   instruction_fetch_if b1 ();

   instruction_fetch dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   instruction_fetch #(.RESET_PC(16'hFFFF)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      b1.mem_ack   = 1'b1;
      b1.dec_ready = 1'b1;
      b1.br_taken  = 1'b0;
      b1.br_target = 16'h0000;
      b1.mem_rdata = 16'hBEEF;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] ins;
      logic [15:0] pc;
   } entry_t;

   typedef struct {
      bit          ack;
      bit          rdy;
      bit          br;
      logic [15:0] tgt;
      bit          req;
      logic [15:0] addr;
      bit          valid;
      logic [15:0] ins;
      logic [15:0] pc;
   } step_t;

   // Model: a single request slot (busy/drop/address), the next fetch address and the instruction queue.
   bit          m_busy;
   bit          m_drop;
   logic [15:0] m_addr;
   logic [15:0] m_pc;
   entry_t      q[$];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0000) return 16'h1704;
      if (a == 16'h0001) return 16'h2A05;
      return 16'(a * 16'd40503) ^ 16'h5A5A;
   endfunction

   function automatic logic [49:0] model_out();
      logic [15:0] ins;
      logic [15:0] pc;
      ins = (q.size() != 0) ? q[0].ins : 16'h0000;
      pc  = (q.size() != 0) ? q[0].pc  : 16'h0000;
      return {m_busy, m_addr, (q.size() != 0), ins, pc};
   endfunction

   function automatic logic [49:0] dut_out();
      return {b0.mem_req, b0.mem_addr, b0.instr_valid, b0.instr, b0.instr_pc};
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_addr = 16'h0000;
      m_pc   = 16'h0000;
      q.delete();
   endtask

   task automatic model_step(input bit ack, input bit rdy, input bit br,
                             input logic [15:0] tgt, input logic [15:0] rdata);
      int sz;
      sz = q.size();
      if (br) begin
         q.delete();
         m_pc = tgt;
         if (m_busy) begin
            if (ack) begin
               m_busy = 1'b0;
               m_drop = 1'b0;
            end else begin
               m_drop = 1'b1;
            end
         end
      end else begin
         if (sz > 0 && rdy) void'(q.pop_front());
         if (m_busy) begin
            if (ack) begin
               if (!m_drop) q.push_back('{ins: rdata, pc: m_addr});
               m_busy = 1'b0;
               m_drop = 1'b0;
            end
         end else if (sz < 2) begin
            m_addr = m_pc;
            m_pc   = m_pc + 16'd1;
            m_busy = 1'b1;
         end
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, advance the model at the rising edge.
   task automatic apply(input bit ack, input bit rdy, input bit br, input logic [15:0] tgt);
      logic [15:0] rdata;
      rdata        = mem_word(m_addr);
      b0.mem_ack   = ack;
      b0.dec_ready = rdy;
      b0.br_taken  = br;
      b0.br_target = tgt;
      b0.mem_rdata = rdata;
      @(posedge clk);
      model_step(ack, rdy, br, tgt, rdata);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      b0.mem_ack   = 1'b0;
      b0.dec_ready = 1'b0;
      b0.br_taken  = 1'b0;
      b0.br_target = 16'h0000;
      b0.mem_rdata = 16'h0000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [49:0] obs;
      rst_n = 1'b1;
      b0.mem_ack = 1'b1; b0.dec_ready = 1'b1; b0.br_taken = 1'b0;
      b0.br_target = 16'h0000; b0.mem_rdata = 16'h0000;
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      obs = dut_out();
      if (obs !== 50'h0) begin
         $display("FAIL reset_hold got=%h exp=%h", obs, 50'h0);
         failures++;
      end
      checks++;
      if ({b1.mem_req, b1.mem_addr, b1.instr_valid} !== 18'h0) begin
         $display("FAIL reset_hold_pcffff got=%h exp=%h", {b1.mem_req, b1.mem_addr, b1.instr_valid}, 18'h0);
         failures++;
      end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      obs = dut_out();
      if (obs !== model_out()) begin
         $display("FAIL reset_release got=%h exp=%h", obs, model_out());
         failures++;
      end
      checks++;
   endtask

   task automatic test_sequential();
      step_t       tbl [5];
      logic [49:0] obs;
      tbl = '{
         '{1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000},
         '{1, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h1704, 16'h0000},
         '{1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 16'h0000},
         '{1, 1, 0, 16'h0, 0, 16'h0001, 1, 16'h2A05, 16'h0001},
         '{1, 1, 0, 16'h0, 1, 16'h0002, 0, 16'h0000, 16'h0000}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
         obs = dut_out();
         if (obs !== {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc}) begin
            $display("FAIL sequential step=%0d got=%h exp=%h", i, obs,
                     {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc});
            failures++;
         end
         checks++;
         if (obs !== model_out()) begin
            $display("FAIL sequential_model step=%0d got=%h exp=%h", i, obs, model_out());
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_full();
      step_t       tbl [10];
      logic [49:0] obs;
      tbl = '{
         '{1, 0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000},
         '{1, 0, 0, 16'h0, 0, 16'h0000, 1, 16'h1704, 16'h0000},
         '{1, 0, 0, 16'h0, 1, 16'h0001, 1, 16'h1704, 16'h0000},
         '{1, 0, 0, 16'h0, 0, 16'h0001, 1, 16'h1704, 16'h0000},
         '{1, 0, 0, 16'h0, 0, 16'h0001, 1, 16'h1704, 16'h0000},
         '{1, 0, 0, 16'h0, 0, 16'h0001, 1, 16'h1704, 16'h0000},
         '{1, 1, 0, 16'h0, 0, 16'h0001, 1, 16'h2A05, 16'h0001},
         '{1, 0, 0, 16'h0, 1, 16'h0002, 1, 16'h2A05, 16'h0001},
         '{1, 0, 0, 16'h0, 0, 16'h0002, 1, 16'h2A05, 16'h0001},
         '{1, 0, 0, 16'h0, 0, 16'h0002, 1, 16'h2A05, 16'h0001}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
         obs = dut_out();
         if (obs !== {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc}) begin
            $display("FAIL full step=%0d got=%h exp=%h", i, obs,
                     {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc});
            failures++;
         end
         checks++;
         if (obs !== model_out()) begin
            $display("FAIL full_model step=%0d got=%h exp=%h", i, obs, model_out());
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_drop();
      step_t       tbl [7];
      logic [49:0] obs;
      tbl = '{
         '{0, 1, 1, 16'h0005, 0, 16'h0000, 0, 16'h0000, 16'h0000},
         '{0, 1, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000},
         '{0, 1, 1, 16'h0040, 1, 16'h0005, 0, 16'h0000, 16'h0000},
         '{0, 1, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000},
         '{0, 1, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000},
         '{1, 1, 0, 16'h0000, 0, 16'h0005, 0, 16'h0000, 16'h0000},
         '{0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
         obs = dut_out();
         if (obs !== {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc}) begin
            $display("FAIL drop step=%0d got=%h exp=%h", i, obs,
                     {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc});
            failures++;
         end
         checks++;
         if (obs !== model_out()) begin
            $display("FAIL drop_model step=%0d got=%h exp=%h", i, obs, model_out());
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_redirect_collision();
      step_t       tbl [5];
      logic [49:0] obs;
      tbl = '{
         '{1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000},
         '{1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1704, 16'h0000},
         '{0, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h1704, 16'h0000},
         '{1, 1, 1, 16'h0123, 0, 16'h0001, 0, 16'h0000, 16'h0000},
         '{0, 1, 0, 16'h0000, 1, 16'h0123, 0, 16'h0000, 16'h0000}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
         obs = dut_out();
         if (obs !== {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc}) begin
            $display("FAIL collision step=%0d got=%h exp=%h", i, obs,
                     {tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].ins, tbl[i].pc});
            failures++;
         end
         checks++;
         if (obs !== model_out()) begin
            $display("FAIL collision_model step=%0d got=%h exp=%h", i, obs, model_out());
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      @(posedge clk);
      @(negedge clk);
      if ({b1.mem_req, b1.mem_addr} !== {1'b1, 16'hFFFF}) begin
         $display("FAIL wrap_first got=%h exp=%h", {b1.mem_req, b1.mem_addr}, {1'b1, 16'hFFFF});
         failures++;
      end
      checks++;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      if ({b1.mem_req, b1.mem_addr} !== {1'b1, 16'h0000}) begin
         $display("FAIL wrap_second got=%h exp=%h", {b1.mem_req, b1.mem_addr}, {1'b1, 16'h0000});
         failures++;
      end
      checks++;
   endtask

   task automatic test_async_reset();
      logic [49:0] obs;
      do_reset();
      apply(1'b1, 1'b0, 1'b0, 16'h0000);
      apply(1'b1, 1'b0, 1'b0, 16'h0000);
      apply(1'b0, 1'b0, 1'b0, 16'h0000);
      obs = dut_out();
      if (obs !== model_out()) begin
         $display("FAIL async_pre got=%h exp=%h", obs, model_out());
         failures++;
      end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if ({b0.mem_req, b0.instr_valid, b0.mem_addr} !== 18'h0) begin
         $display("FAIL async_immediate got=%h exp=%h", {b0.mem_req, b0.instr_valid, b0.mem_addr}, 18'h0);
         failures++;
      end
      checks++;
      rst_n = 1'b1;
      model_reset();
      // A late ack for the abandoned request arrives while back in IDLE.
      apply(1'b1, 1'b1, 1'b0, 16'h0000);
      obs = dut_out();
      if ({b0.mem_req, b0.mem_addr, b0.instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin
         $display("FAIL async_first_req got=%h exp=%h", {b0.mem_req, b0.mem_addr, b0.instr_valid},
                  {1'b1, 16'h0000, 1'b0});
         failures++;
      end
      checks++;
      if (obs !== model_out()) begin
         $display("FAIL async_model got=%h exp=%h", obs, model_out());
         failures++;
      end
      checks++;
   endtask

   task automatic test_random();
      logic [49:0] obs;
      bit          ack;
      bit          rdy;
      bit          br;
      logic [15:0] tgt;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         ack = ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 11) == 0);
         tgt = 16'($urandom);
         apply(ack, rdy, br, tgt);
         obs = dut_out();
         if (obs !== model_out()) begin
            $display("FAIL random cyc=%0d got=%h exp=%h", n, obs, model_out());
            failures++;
         end
         checks++;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_sequential();
      test_full();
      test_drop();
      test_redirect_collision();
      test_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
